// File: rtl/ge_pkg.sv
// ge_pkg: shared node op codes, pass modes and feeder state encoding for the GE array.
package ge_pkg;
  typedef enum logic [1:0] {OP_PASS = 2'b00, OP_SWAP = 2'b01, OP_ADD = 2'b10, OP_NOP = 2'b11} op_t;
  typedef enum logic {MODE_TRI = 1'b0, MODE_SYS = 1'b1} mode_t;
  typedef enum logic [1:0] {IDLE, FEED, OFFLOAD, DRAIN} feed_state_t;
endpackage

// File: rtl/ge_skew_line.sv
// ge_skew_line: DEPTH-stage delay of one column's {data,start,swap} triple, async cleared.
module ge_skew_line
  import ge_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [DEPTH-1:0][2:0] sr;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/ge_array_feeder.sv
// ge_array_feeder: feeds command-driven row passes into the GE array top edge with per-column skew.
module ge_array_feeder
  import ge_pkg::*;
#(
  parameter int N_COL = 8,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [ROW_W-1:0] cmd_rows,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [N_COL-1:0] row_data,
  output logic             mode_o,
  output logic [N_COL-1:0] start_o,
  output logic [N_COL-1:0] swap_o,
  output logic [N_COL-1:0] data_o,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] bubble_cnt
);
  localparam int PW = $clog2(N_COL) + 1;
  feed_state_t state;
  logic [ROW_W-1:0] rows, row_cnt;
  logic [PW-1:0] pcnt;
  logic take, s_start, s_swap;
  logic [N_COL-1:0] s_data;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign row_ready = state == FEED;
  assign take = row_valid && row_ready;
  assign s_data = take ? row_data : '0;
  assign s_start = take && row_cnt == '0;
  assign s_swap = state == OFFLOAD;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= IDLE;
      mode_o <= MODE_TRI;
      rows <= '0;
      row_cnt <= '0;
      bubble_cnt <= '0;
      pcnt <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          mode_o <= cmd_mode;
          rows <= cmd_rows;
          row_cnt <= '0;
          bubble_cnt <= '0;
          pcnt <= '0;
          state <= cmd_rows == '0 ? OFFLOAD : FEED;
        end
        FEED: if (take) begin
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == rows - 1'b1) state <= OFFLOAD;
        end else if (!(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
        OFFLOAD: begin
          pcnt <= pcnt == PW'(N_COL - 1) ? '0 : pcnt + 1'b1;
          if (pcnt == PW'(N_COL - 1)) state <= DRAIN;
        end
        DRAIN: begin
          pcnt <= pcnt + 1'b1;
          if (pcnt == PW'(N_COL - 2)) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  // column j sees the slot j cycles after column 0
  for (genvar j = 0; j < N_COL; j++) begin : g_col
    ge_skew_line #(.DEPTH(j + 1)) u_skew (
      .clk  (clk),
      .rst_b(rst_b),
      .d    ({s_data[j], s_start, s_swap}),
      .q    ({data_o[j], start_o[j], swap_o[j]})
    );
  end
endmodule
